// File: rtl/memory_bus.sv
// memory_bus: bus controller between the F100-L core and its memories and
// peripherals. Decodes the core word address onto an external 2048x16 block
// RAM (registered read, one cycle latency) or a four-register peripheral page.
// It also runs the request/ready handshake the core waits on.
//
// Optional feature macro: MEMORY_BUS_TIMER_EN adds a free-running timer at
// IO_BASE+3. Without it, IO_BASE+3 reads 0 and writes to it are ignored.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   address/data_in   core word address and write data
//   bus_enable        core request strobe; write_enable selects write/read
//   data_out          read data, valid while data_ready=1
//   data_ready        one-cycle completion pulse
//   ram_*             external RAM address/data/write strobe, registered read data
//   leds, ioport_out  output registers
//   ioport_in         asynchronous input port (two-flop synchronised)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for bus_enable; decode and issue the access
// RAM_READ | RAM has the address; capture its registered output next edge
// DONE     | data_ready pulsed; wait for bus_enable to drop
module memory_bus #(
  parameter logic [15:0] IO_BASE   = 16'h8000,
  parameter int unsigned TIMER_DIV = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  input  logic        bus_enable,
  input  logic        write_enable,
  output logic        data_ready,
  output logic [10:0] ram_address,
  output logic [15:0] ram_data_in,
  input  logic [15:0] ram_data_out,
  output logic        ram_write_enable,
  output logic [7:0]  leds,
  output logic [15:0] ioport_out,
  input  logic [15:0] ioport_in
);

  typedef enum logic [1:0] {IDLE, RAM_READ, DONE} state_t;

  localparam logic [15:0] IO_LEDS_ADDR  = IO_BASE;
  localparam logic [15:0] IO_OUT_ADDR   = IO_BASE + 16'd1;
  localparam logic [15:0] IO_IN_ADDR    = IO_BASE + 16'd2;
  localparam logic [15:0] IO_TIMER_ADDR = IO_BASE + 16'd3;

  generate
    if (TIMER_DIV < 1 || TIMER_DIV > 65535) begin : g_bad_timer_div
      $error("memory_bus: TIMER_DIV must be in 1..65535");
    end
  endgenerate

  state_t state;
  state_t state_next;

  logic        in_ram;
  logic        req_idle;
  logic [15:0] sync_1;
  logic [15:0] sync_2;
  logic [15:0] timer_rdata;
  logic [15:0] periph_rdata;

  assign in_ram      = (address[15:11] == 5'd0);
  assign req_idle    = (state == IDLE) && bus_enable;
  assign ram_address = address[10:0];
  assign ram_data_in = data_in;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (bus_enable) state_next = (in_ram && !write_enable) ? RAM_READ : DONE;
      RAM_READ: state_next = DONE;
      DONE:     if (!bus_enable) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Output logic: the RAM strobe is combinational so the write lands on the
  // same edge that leaves IDLE; reset masks it so an aborted cycle never writes.
  always_comb begin
    ram_write_enable = 1'b0;
    if (!reset && req_idle && write_enable && in_ram) ram_write_enable = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= ioport_in;
      sync_2 <= sync_1;
    end
  end

`ifdef MEMORY_BUS_TIMER_EN
  localparam logic [15:0] PRESCALE_LAST = 16'(TIMER_DIV - 1);

  logic [15:0] prescaler;
  logic [15:0] timer;
  logic        timer_clear;

  assign timer_clear = req_idle && write_enable && (address == IO_TIMER_ADDR);

  // A clear from the core beats a coincident tick.
  always_ff @(posedge clk) begin
    if (reset || timer_clear) begin
      prescaler <= '0;
      timer     <= '0;
    end else if (prescaler == PRESCALE_LAST) begin
      prescaler <= '0;
      timer     <= timer + 16'd1;
    end else begin
      prescaler <= prescaler + 16'd1;
    end
  end

  assign timer_rdata = timer;
`else
  assign timer_rdata = '0;
`endif

  always_comb begin
    periph_rdata = '0;
    case (address)
      IO_LEDS_ADDR:  periph_rdata = {8'h00, leds};
      IO_OUT_ADDR:   periph_rdata = ioport_out;
      IO_IN_ADDR:    periph_rdata = sync_2;
      IO_TIMER_ADDR: periph_rdata = timer_rdata;
      default:       periph_rdata = '0;
    endcase
  end

  // Data path and completion pulse. Unmapped addresses fall through the
  // peripheral mux as 0, so they need no special case here.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      data_ready <= 1'b0;
      leds       <= '0;
      ioport_out <= '0;
    end else begin
      data_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (bus_enable) begin
            if (!in_ram) begin
              if (write_enable) begin
                if (address == IO_LEDS_ADDR) leds       <= data_in[7:0];
                if (address == IO_OUT_ADDR)  ioport_out <= data_in;
              end else begin
                data_out <= periph_rdata;
              end
            end
            data_ready <= !(in_ram && !write_enable);
          end
        end
        RAM_READ: begin
          data_out   <= ram_data_out;
          data_ready <= 1'b1;
        end
        default: data_ready <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bus.sv
module tb_memory_bus;

  localparam logic [15:0] IO = 16'h8000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        bus_enable;
  logic        write_enable;
  logic        data_ready;
  logic [10:0] ram_address;
  logic [15:0] ram_data_in;
  logic [15:0] ram_data_out;
  logic        ram_write_enable;
  logic [7:0]  leds;
  logic [15:0] ioport_out;
  logic [15:0] ioport_in;

  int checks = 0;
  int errors = 0;

  memory_bus #(.IO_BASE(IO), .TIMER_DIV(4)) dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .data_out(data_out), .bus_enable(bus_enable), .write_enable(write_enable),
    .data_ready(data_ready), .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .ram_write_enable(ram_write_enable),
    .leds(leds), .ioport_out(ioport_out), .ioport_in(ioport_in)
  );

  always #5 clk = ~clk;

  // Block RAM with registered read.
  logic [15:0] mem [0:2047];
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_address] <= ram_data_in;
    ram_data_out <= mem[ram_address];
  end

  // One transaction; lat=0 means data_ready never came within the budget.
  task automatic do_access(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                           input int hold, output logic [15:0] rd, output int lat,
                           output int we_cnt, output int rdy_cnt);
    @(negedge clk);
    address = addr; data_in = wd; write_enable = we; bus_enable = 1'b1;
    rd = '0; lat = 0; we_cnt = 0; rdy_cnt = 0;
    for (int n = 1; n <= 10; n++) begin
      #1;
      if (ram_write_enable) we_cnt++;
      @(posedge clk); #1;
      if (data_ready) begin lat = n; rd = data_out; rdy_cnt = 1; break; end
    end
    for (int n = 0; n < hold; n++) begin
      if (ram_write_enable) we_cnt++;
      @(posedge clk); #1;
      if (data_ready) rdy_cnt++;
    end
    @(negedge clk);
    bus_enable = 1'b0; write_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; bus_enable = 1'b0; write_enable = 1'b0;
    address = '0; data_in = '0; ioport_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", data_ready); end
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL reset_data got %h exp 0000", data_out); end
    checks++; if (leds !== 8'h0) begin errors++; $display("FAIL reset_leds got %h exp 00", leds); end
    checks++; if (ioport_out !== 16'h0) begin errors++; $display("FAIL reset_ioport got %h exp 0000", ioport_out); end
  endtask

  task automatic test_ram;
    logic [15:0] rd; int lat, wc, rc;
    do_access(1'b1, 16'h0005, 16'h1234, 1, rd, lat, wc, rc);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ram_write_latency got %0d exp 1", lat); end
    checks++; if (wc !== 1) begin errors++; $display("FAIL ram_write_strobes got %0d exp 1", wc); end
    checks++; if (rc !== 1) begin errors++; $display("FAIL ram_write_ready_pulses got %0d exp 1", rc); end
    do_access(1'b0, 16'h0005, 16'h0000, 1, rd, lat, wc, rc);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ram_read_latency got %0d exp 2", lat); end
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL ram_read_data got %h exp 1234", rd); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL ram_read_strobes got %0d exp 0", wc); end
    do_access(1'b1, 16'h07FF, 16'hCAFE, 0, rd, lat, wc, rc);
    do_access(1'b0, 16'h07FF, 16'h0000, 0, rd, lat, wc, rc);
    checks++; if (rd !== 16'hCAFE) begin errors++; $display("FAIL ram_top_word got %h exp cafe", rd); end
  endtask

  task automatic test_periph;
    logic [15:0] rd; int lat, wc, rc;
    do_access(1'b1, IO, 16'h12A5, 0, rd, lat, wc, rc);
    checks++; if (leds !== 8'hA5) begin errors++; $display("FAIL leds_write got %h exp a5", leds); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL leds_write_ram_strobe got %0d exp 0", wc); end
    do_access(1'b0, IO, 16'h0000, 0, rd, lat, wc, rc);
    checks++; if (rd !== 16'h00A5) begin errors++; $display("FAIL leds_read got %h exp 00a5", rd); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL periph_read_latency got %0d exp 1", lat); end
    do_access(1'b1, IO + 16'd1, 16'hC3C3, 0, rd, lat, wc, rc);
    checks++; if (ioport_out !== 16'hC3C3) begin errors++; $display("FAIL ioport_out_write got %h exp c3c3", ioport_out); end
    do_access(1'b0, IO + 16'd1, 16'h0000, 0, rd, lat, wc, rc);
    checks++; if (rd !== 16'hC3C3) begin errors++; $display("FAIL ioport_out_read got %h exp c3c3", rd); end
  endtask

  task automatic test_ioport_in;
    logic [15:0] rd; int lat, wc, rc;
    ioport_in = 16'hBEEF;
    repeat (3) @(negedge clk);
    do_access(1'b0, IO + 16'd2, 16'h0000, 0, rd, lat, wc, rc);
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL ioport_in_read got %h exp beef", rd); end
    // New value one edge before the read edge: only the first flop has it.
    ioport_in = 16'h1111;
    do_access(1'b0, IO + 16'd2, 16'h0000, 0, rd, lat, wc, rc);
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL ioport_in_sync_depth got %h exp beef", rd); end
    do_access(1'b0, IO + 16'd2, 16'h0000, 0, rd, lat, wc, rc);
    checks++; if (rd !== 16'h1111) begin errors++; $display("FAIL ioport_in_new got %h exp 1111", rd); end
  endtask

  task automatic test_hold_and_unmapped;
    logic [15:0] rd; int lat, wc, rc;
    do_access(1'b1, 16'h0006, 16'h5555, 5, rd, lat, wc, rc);
    checks++; if (wc !== 1) begin errors++; $display("FAIL hold_ram_strobes got %0d exp 1", wc); end
    checks++; if (rc !== 1) begin errors++; $display("FAIL hold_ready_pulses got %0d exp 1", rc); end
    do_access(1'b1, 16'h0001, 16'h7777, 0, rd, lat, wc, rc);
    do_access(1'b1, 16'h0801, 16'hDEAD, 0, rd, lat, wc, rc);
    checks++; if (wc !== 0) begin errors++; $display("FAIL unmapped_write_strobe got %0d exp 0", wc); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL unmapped_write_latency got %0d exp 1", lat); end
    do_access(1'b0, 16'h0001, 16'h0000, 0, rd, lat, wc, rc);
    checks++; if (rd !== 16'h7777) begin errors++; $display("FAIL alias_untouched got %h exp 7777", rd); end
    do_access(1'b0, 16'h0800, 16'h0000, 0, rd, lat, wc, rc);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL unmapped_read got %h exp 0000", rd); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL unmapped_read_latency got %0d exp 1", lat); end
    do_access(1'b0, IO + 16'd4, 16'h0000, 0, rd, lat, wc, rc);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL io_gap_read got %h exp 0000", rd); end
    @(negedge clk);
    address = 16'h0805;
    #1;
    checks++; if (ram_address !== 11'h005) begin errors++; $display("FAIL ram_address_passthru got %h exp 005", ram_address); end
  endtask

  task automatic test_reset_abort;
    logic [15:0] rd; int lat, wc, rc;
    @(negedge clk);
    address = 16'h0005; write_enable = 1'b0; bus_enable = 1'b1;
    @(posedge clk); #1;
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL abort_early_ready got %b exp 0", data_ready); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %b exp 0", data_ready); end
    checks++; if (leds !== 8'h00) begin errors++; $display("FAIL abort_leds got %h exp 00", leds); end
    write_enable = 1'b1; data_in = 16'hFFFF;
    #1;
    checks++; if (ram_write_enable !== 1'b0) begin errors++; $display("FAIL reset_masks_strobe got %b exp 0", ram_write_enable); end
    @(negedge clk);
    reset = 1'b0; bus_enable = 1'b0; write_enable = 1'b0;
    rc = 0;
    repeat (3) begin @(posedge clk); #1; if (data_ready) rc++; end
    checks++; if (rc !== 0) begin errors++; $display("FAIL abort_no_ready got %0d exp 0", rc); end
    do_access(1'b0, 16'h0005, 16'h0000, 0, rd, lat, wc, rc);
    checks++; if (lat !== 2) begin errors++; $display("FAIL post_abort_latency got %0d exp 2", lat); end
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL post_abort_data got %h exp 1234", rd); end
  endtask

  task automatic test_timer;
    logic [15:0] rd; int lat, wc, rc;
    do_access(1'b1, IO + 16'd3, 16'h0000, 0, rd, lat, wc, rc);
    repeat (40) @(negedge clk);
    do_access(1'b0, IO + 16'd3, 16'h0000, 0, rd, lat, wc, rc);
`ifdef MEMORY_BUS_TIMER_EN
    checks++; if (rd < 16'd9 || rd > 16'd11) begin errors++; $display("FAIL timer_count got %0d exp 9..11", rd); end
    do_access(1'b1, IO + 16'd3, 16'h0000, 0, rd, lat, wc, rc);
    do_access(1'b0, IO + 16'd3, 16'h0000, 0, rd, lat, wc, rc);
    checks++; if (rd > 16'd1) begin errors++; $display("FAIL timer_clear got %0d exp 0..1", rd); end
`else
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL timer_absent got %h exp 0000", rd); end
`endif
  endtask

  initial begin
    test_reset;
    test_ram;
    test_periph;
    test_ioport_in;
    test_hold_and_unmapped;
    test_reset_abort;
    test_timer;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
